// File: rtl/pow_seq.sv
// pow_seq: computes base^exp (mod 2^BITS) by repeated multiplication
// on a shared combinational multiplier, with start/busy/done handshake.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         request; accepted when idle or on the done cycle
//   base, exp     operands, captured with an accepted start
//   mul_a, mul_b  operands driven to the shared multiplier
//   mul_p         multiplier product (low BITS of mul_a*mul_b)
//   busy          high while multiplying
//   done          one-cycle completion pulse
//   result        last completed result, held until the next completion
module pow_seq #(
  parameter int BITS  = 8,
  parameter int EBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BITS-1:0]  base,
  input  logic [EBITS-1:0] exp,
  output logic [BITS-1:0]  mul_a,
  output logic [BITS-1:0]  mul_b,
  input  logic [BITS-1:0]  mul_p,
  output logic             busy,
  output logic             done,
  output logic [BITS-1:0]  result
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [BITS-1:0]  acc_r;
  logic [BITS-1:0]  base_r;
  logic [EBITS-1:0] cnt_r;
  logic [BITS-1:0]  res_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc_r  <= '0;
      base_r <= '0;
      cnt_r  <= '0;
      res_r  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            base_r <= base;
            acc_r  <= BITS'(1);
            cnt_r  <= exp;
            // x^0 completes immediately with no multiply
            if (exp == '0) begin
              state <= DONE;
              res_r <= BITS'(1);
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc_r <= mul_p;
          cnt_r <= cnt_r - EBITS'(1);
          if (cnt_r == EBITS'(1)) begin
            res_r <= mul_p;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mul_a  = acc_r;
  assign mul_b  = base_r;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign result = res_r;

endmodule

// File: tb/tb_pow_seq.sv
// tb_pow_seq: randomized and directed checks of pow_seq against
// a plain-arithmetic power model and latency rules.
module tb_pow_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base = '0;
  logic [3:0] exp = '0;
  logic [7:0] mul_a, mul_b, mul_p;
  logic       busy, done;
  logic [7:0] result;

  int total = 0;
  int passed = 0;
  logic [7:0] ma_log [16];

  always #5 clk = ~clk;

  // Shared truncating multiplier that the sequencer drives
  assign mul_p = mul_a * mul_b;

  pow_seq #(.BITS(8), .EBITS(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base(base), .exp(exp),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .busy(busy), .done(done), .result(result)
  );

  function automatic logic [7:0] ref_pow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % 256;
    return r[7:0];
  endfunction

  // Counts busy cycles and the offset of the first done sample,
  // starting at the current negedge; logs mul_a during busy.
  task automatic wait_done(output int lat, output int nb);
    lat = -1;
    nb  = 0;
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge clk);
      if (done) begin
        lat = j;
        break;
      end
      if (busy) begin
        if (nb < 16) ma_log[nb] = mul_a;
        nb++;
      end
    end
  endtask

  // Starts an op, ends on the done negedge
  task automatic do_op(input logic [7:0] b, input logic [3:0] e,
                       output int lat, output int nb);
    @(negedge clk);
    start = 1'b1; base = b; exp = e;
    @(negedge clk);
    start = 1'b0; base = 8'($urandom); exp = 4'($urandom);
    wait_done(lat, nb);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    total++; if (result !== 8'd0) $display("FAIL rst_result: got %0d want 0", result); else passed++;
    total++; if (mul_a !== 8'd0) $display("FAIL rst_mul_a: got %0d want 0", mul_a); else passed++;
    total++; if (mul_b !== 8'd0) $display("FAIL rst_mul_b: got %0d want 0", mul_b); else passed++;
  endtask

  task automatic test_basic();
    int lat, nb;
    logic [7:0] want [4];
    want = '{8'd1, 8'd3, 8'd9, 8'd27};
    do_op(8'd3, 4'd4, lat, nb);
    total++; if (nb !== 4) $display("FAIL basic_busy: got %0d want 4", nb); else passed++;
    total++; if (lat !== 4) $display("FAIL basic_lat: got %0d want 4", lat); else passed++;
    total++; if (result !== 8'd81) $display("FAIL basic_result: got %0d want 81", result); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ma_log[i] !== want[i])
        $display("FAIL basic_mul_a[%0d]: got %0d want %0d", i, ma_log[i], want[i]);
      else passed++;
    end
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL basic_pulse: got %b want 0", done); else passed++;
    total++; if (result !== 8'd81) $display("FAIL basic_hold: got %0d want 81", result); else passed++;
  endtask

  task automatic test_wrap();
    int lat, nb;
    do_op(8'd2, 4'd9, lat, nb);
    total++; if (nb !== 9) $display("FAIL wrap_busy: got %0d want 9", nb); else passed++;
    total++; if (lat !== 9) $display("FAIL wrap_lat: got %0d want 9", lat); else passed++;
    total++; if (result !== 8'd0) $display("FAIL wrap_result: got %0d want 0", result); else passed++;
  endtask

  task automatic test_zero_exp();
    int lat, nb;
    do_op(8'd7, 4'd0, lat, nb);
    total++; if (nb !== 0) $display("FAIL z_busy: got %0d want 0", nb); else passed++;
    total++; if (lat !== 0) $display("FAIL z_lat: got %0d want 0", lat); else passed++;
    total++; if (result !== 8'd1) $display("FAIL z_result: got %0d want 1", result); else passed++;
    do_op(8'd0, 4'd0, lat, nb);
    total++; if (result !== 8'd1) $display("FAIL z00_result: got %0d want 1", result); else passed++;
    do_op(8'd0, 4'd3, lat, nb);
    total++; if (result !== 8'd0) $display("FAIL z03_result: got %0d want 0", result); else passed++;
  endtask

  task automatic test_ignore_and_b2b();
    int lat, nb;
    @(negedge clk);
    start = 1'b1; base = 8'd5; exp = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; base = 8'd9; exp = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb);
    total++; if (lat !== 1) $display("FAIL ign_lat: got %0d want 1", lat); else passed++;
    total++; if (result !== 8'd125) $display("FAIL ign_result: got %0d want 125", result); else passed++;
    // Start in the done cycle
    start = 1'b1; base = 8'd4; exp = 4'd2;
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b0) $display("FAIL b2b_drop: got %b want 0", done); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else passed++;
    wait_done(lat, nb);
    total++; if (lat !== 2) $display("FAIL b2b_lat: got %0d want 2", lat); else passed++;
    total++; if (result !== 8'd16) $display("FAIL b2b_result: got %0d want 16", result); else passed++;
    // exp==0 in the done cycle keeps done high another cycle
    start = 1'b1; base = 8'd200; exp = 4'd0;
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL b2b0_done: got %b want 1", done); else passed++;
    total++; if (result !== 8'd1) $display("FAIL b2b0_result: got %0d want 1", result); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL b2b0_end: got %b want 0", done); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, nb;
    int seen;
    @(negedge clk);
    start = 1'b1; base = 8'd3; exp = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
    total++; if (result !== 8'd0) $display("FAIL rmid_result: got %0d want 0", result); else passed++;
    total++; if (mul_a !== 8'd0) $display("FAIL rmid_mul_a: got %0d want 0", mul_a); else passed++;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      if (done) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) $display("FAIL rmid_nodone: got %0d want 0", seen); else passed++;
    do_op(8'd2, 4'd3, lat, nb);
    total++; if (result !== 8'd8) $display("FAIL rmid_after: got %0d want 8", result); else passed++;
    total++; if (lat !== 3) $display("FAIL rmid_lat: got %0d want 3", lat); else passed++;
  endtask

  task automatic test_random();
    int lat, nb;
    logic [7:0] b;
    logic [3:0] e;
    for (int n = 0; n < 25; n++) begin
      b = 8'($urandom);
      e = 4'($urandom_range(0, 15));
      do_op(b, e, lat, nb);
      total++;
      if (result !== ref_pow(b, e))
        $display("FAIL rnd_result: %0d^%0d got %0d want %0d", b, e, result, ref_pow(b, e));
      else passed++;
      total++;
      if (lat !== int'(e)) $display("FAIL rnd_lat: got %0d want %0d", lat, e); else passed++;
      total++;
      if (nb !== int'(e)) $display("FAIL rnd_busy: got %0d want %0d", nb, e); else passed++;
      for (int i = 0; i < int'(e); i++) begin
        total++;
        if (ma_log[i] !== ref_pow(b, i))
          $display("FAIL rnd_mul_a[%0d]: got %0d want %0d", i, ma_log[i], ref_pow(b, i));
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_exp();
    test_ignore_and_b2b();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pow_seq.md
Name: pow_seq

Overview:
- Sequencer that computes base^exp, truncated to BITS, by driving one shared combinational BITS-wide multiplier (out = a*b, low BITS kept) with repeated multiplication.
- Sits between the calculator's operation decoder and the multiplier instance.
- Owns the multiplier operand buses while busy.
- Start/busy/done handshake toward the decoder.

Parameters:
- BITS, 8, operand/result/multiplier width.
- EBITS, 4, exponent width (exp range 0..2^EBITS-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled each rising edge.
- base  input  BITS  base operand; sampled with an accepted start.
- exp  input  EBITS  exponent; sampled with an accepted start.
- mul_a  output  BITS  multiplier operand a.
- mul_b  output  BITS  multiplier operand b.
- mul_p  input  BITS  multiplier product (combinational from mul_a, mul_b).
- busy  output  1  high while multiplying.
- done  output  1  one-cycle completion pulse.
- result  output  BITS  last completed result; held until the next completion.

Behaviour:
- Registers:
  - state: IDLE, RUN, DONE.
  - acc_r (BITS), base_r (BITS), cnt_r (EBITS), res_r (BITS).
- Outputs:
  - mul_a = acc_r, mul_b = base_r.
  - busy = (state==RUN), done = (state==DONE), result = res_r.
- Reset (rst=1 at an edge):
  - state=IDLE; acc_r, base_r, cnt_r, res_r = 0.
  - Outputs therefore busy=0, done=0, result=0, mul_a=mul_b=0.
  - Reset has priority over everything, including mid-RUN: the operation is abandoned, no done pulse, result=0.
- start is accepted when state is IDLE or DONE.
  - At accepting edge k: base_r<=base, acc_r<=1, cnt_r<=exp.
  - exp==0: state<=DONE, res_r<=1.
  - exp!=0: state<=RUN.
- start while RUN is ignored; inputs are not captured.
- RUN, each edge:
  - acc_r<=mul_p; cnt_r<=cnt_r-1.
  - When cnt_r==1 at that edge: res_r<=mul_p, state<=DONE.
- DONE:
  - Without start: state<=IDLE.
  - With start: accept a new op (back-to-back); done drops for at least the next cycle unless exp==0, in which case done stays high for a second consecutive cycle with res_r=1.
- Latency:
  - done is high in the cycle after edge k+exp, where k is the accepting edge.
  - busy is high for exactly exp cycles, 0 for exp==0.
- Arithmetic:
  - All products are taken modulo 2^BITS, because the multiplier truncates.
  - No overflow flag.
  - base=0 with exp>0 gives 0; 0^0 gives 1.
- result changes only on the edge that enters DONE, or on reset; it is stable during RUN.
- base and exp may change freely after the accepting edge.

Test Plan:
- BITS=8, rst 2 cycles -> busy=0, done=0, result=0, mul_a=mul_b=0.
- start with base=3, exp=4 at edge k:
  - mul_a sequence 1,3,9,27.
  - busy high for 4 cycles.
  - done pulse after edge k+4.
  - result=81, held after done.
- start with base=2, exp=9 -> result=0 (512 mod 256), done after 9 RUN cycles.
- start with base=7, exp=0 -> busy never high, done the cycle after the accepting edge, result=1.
- base=5, exp=3; start re-pulsed with base=9, exp=2 during RUN -> ignored, result=125.
  - Then start in the DONE cycle with base=4, exp=2 -> accepted back-to-back, result=16.
- base=3, exp=5; rst asserted at the 3rd RUN cycle -> state IDLE, no done pulse, result=0.
  - A new start with base=2, exp=3 then yields 8.
